// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic MAC array slice.
// Holds the job FSM state encoding and the parameter defaults used by every file.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } sa_state_e;

  localparam int SA_ROWS     = 8;
  localparam int SA_COLS     = 4;
  localparam int SA_DATA_W   = 8;
  localparam int SA_ACC_W    = 32;
  localparam int SA_SATURATE = 0;

endpackage

// File: rtl/sa_if.sv
// Operand-beat and result handshake bundle of the systolic MAC array.
// The master side feeds operands and consumes results; the array is the slave.
interface sa_if
  import sa_pkg::*;
#(
  parameter int ROWS   = SA_ROWS,
  parameter int COLS   = SA_COLS,
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   act_in;
  logic [COLS*DATA_W-1:0]   wgt_in;
  logic                     res_valid;
  logic                     res_ready;
  logic [ACC_W-1:0]         res_data;
  logic [ROW_W-1:0]         res_row;
  logic [COL_W-1:0]         res_col;

  modport master (
    output in_valid, act_in, wgt_in, res_ready,
    input  in_ready, res_valid, res_data, res_row, res_col
  );

  modport slave (
    input  in_valid, act_in, wgt_in, res_ready,
    output in_ready, res_valid, res_data, res_row, res_col
  );
endinterface

// File: rtl/sa_pe.sv
// Single systolic MAC cell: passes activation right and weight down one step,
// accumulates the signed product, optionally clamping with a sticky overflow flag.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W   = SA_DATA_W,
  parameter int ACC_W    = SA_ACC_W,
  parameter int SATURATE = SA_SATURATE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] w_out,
  output logic [ACC_W-1:0]  acc
);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic        [ACC_W:0]      sum_s;
  logic                       ovf_s;
  logic        [ACC_W-1:0]    acc_nx_s;
  logic                       sat_nx_s;
  logic        [ACC_W-1:0]    acc_r;
  logic        [DATA_W-1:0]   a_r;
  logic        [DATA_W-1:0]   w_r;
  logic                       sat_r;

  assign prod_s     = $signed(a_in) * $signed(w_in);
  assign prod_ext_s = ACC_W'(prod_s);
  // One guard bit exposes signed overflow as a disagreement of the top two bits.
  assign sum_s      = {acc_r[ACC_W-1], acc_r} + {prod_ext_s[ACC_W-1], prod_ext_s};
  assign ovf_s      = sum_s[ACC_W] ^ sum_s[ACC_W-1];

  always_comb begin
    acc_nx_s = sum_s[ACC_W-1:0];
    sat_nx_s = sat_r;
    if ((SATURATE != 0) && sat_r) begin
      acc_nx_s = acc_r;
    end else if ((SATURATE != 0) && ovf_s) begin
      acc_nx_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
      sat_nx_s = 1'b1;
    end else begin
      acc_nx_s = sum_s[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= {ACC_W{1'b0}};
      a_r   <= {DATA_W{1'b0}};
      w_r   <= {DATA_W{1'b0}};
      sat_r <= 1'b0;
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
      a_r   <= {DATA_W{1'b0}};
      w_r   <= {DATA_W{1'b0}};
      sat_r <= 1'b0;
    end else if (en) begin
      acc_r <= acc_nx_s;
      a_r   <= a_in;
      w_r   <= w_in;
      sat_r <= sat_nx_s;
    end
  end

  assign a_out = a_r;
  assign w_out = w_r;
  assign acc   = acc_r;
endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary ROWS x COLS systolic MAC array with skewed operand entry,
// a stall-safe feed/flush pipeline and a row-major result drain.
module systolic_mac_array
  import sa_pkg::*;
#(
  parameter int ROWS     = SA_ROWS,
  parameter int COLS     = SA_COLS,
  parameter int DATA_W   = SA_DATA_W,
  parameter int ACC_W    = SA_ACC_W,
  parameter int SATURATE = SA_SATURATE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] k_len,
  output logic        busy,
  output logic        done,
  sa_if.slave         bus
);
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NPE       = ROWS * COLS;
  localparam int IDX_W     = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam logic [15:0]      FLUSH_LAST = 16'(FLUSH_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

  sa_state_e          state_r, state_nx;
  logic [15:0]        k_rem_r, flush_cnt_r;
  logic               in_ready_r, res_valid_r, busy_r, done_r;
  logic [ACC_W-1:0]   res_data_r;
  logic [ROW_W-1:0]   row_r, nxt_row_s;
  logic [COL_W-1:0]   col_r, nxt_col_s;
  logic [IDX_W-1:0]   idx_r;
  logic               start_acc_s, beat_s, step_s, flush_end_s, res_hs_s, last_res_s;
  logic [DATA_W-1:0]  a_edge_s [ROWS];
  logic [DATA_W-1:0]  w_edge_s [COLS];
  logic [DATA_W-1:0]  a_pass_s [ROWS][COLS];
  logic [DATA_W-1:0]  w_pass_s [ROWS][COLS];
  logic [ACC_W-1:0]   acc_s [NPE];

  // A start landing on the done cycle is dropped so a finishing job cannot retrigger.
  assign start_acc_s = (state_r == ST_IDLE) && start && !done_r;
  assign beat_s      = in_ready_r && bus.in_valid;
  assign step_s      = beat_s || (state_r == ST_FLUSH);
  assign flush_end_s = (state_r == ST_FLUSH) && (flush_cnt_r == FLUSH_LAST);
  assign res_hs_s    = res_valid_r && bus.res_ready;
  assign last_res_s  = res_hs_s && (row_r == ROW_LAST) && (col_r == COL_LAST);

  always_comb begin
    nxt_row_s = row_r;
    nxt_col_s = col_r + COL_W'(1);
    if (col_r == COL_LAST) begin
      nxt_row_s = row_r + ROW_W'(1);
      nxt_col_s = {COL_W{1'b0}};
    end else begin
      nxt_row_s = row_r;
    end
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) state_nx = (k_len == 16'd0) ? ST_DRAIN : ST_FEED;
        else             state_nx = ST_IDLE;
      end
      ST_FEED: begin
        if (beat_s && (k_rem_r == 16'd1)) state_nx = (FLUSH_LEN == 0) ? ST_DRAIN : ST_FLUSH;
        else                              state_nx = ST_FEED;
      end
      ST_FLUSH: begin
        if (flush_end_s) state_nx = ST_DRAIN;
        else             state_nx = ST_FLUSH;
      end
      ST_DRAIN: begin
        if (last_res_s) state_nx = ST_IDLE;
        else            state_nx = ST_DRAIN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      k_rem_r     <= 16'd0;
      flush_cnt_r <= 16'd0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      in_ready_r  <= (state_nx == ST_FEED);
      busy_r      <= (state_nx != ST_IDLE);
      done_r      <= last_res_s;
      flush_cnt_r <= (state_r == ST_FLUSH) ? flush_cnt_r + 16'd1 : 16'd0;
      if (start_acc_s) k_rem_r <= k_len;
      else if (beat_s) k_rem_r <= k_rem_r - 16'd1;
    end
  end

  // The first DRAIN cycle loads PE(0,0); every accepted result preloads the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {ACC_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      col_r       <= {COL_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
    end else if (state_r == ST_DRAIN) begin
      if (!res_valid_r) begin
        res_valid_r <= 1'b1;
        res_data_r  <= acc_s[0];
        row_r       <= {ROW_W{1'b0}};
        col_r       <= {COL_W{1'b0}};
        idx_r       <= {IDX_W{1'b0}};
      end else if (res_hs_s) begin
        if (last_res_s) begin
          res_valid_r <= 1'b0;
        end else begin
          res_data_r  <= acc_s[idx_r + IDX_W'(1)];
          row_r       <= nxt_row_s;
          col_r       <= nxt_col_s;
          idx_r       <= idx_r + IDX_W'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic [DATA_W-1:0] a_src_s;
    assign a_src_s = (state_r == ST_FEED) ? bus.act_in[r*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    if (r == 0) begin : g_direct
      assign a_edge_s[r] = a_src_s;
    end else begin : g_delay
      logic [DATA_W-1:0] sk_r [r];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < r; i++) sk_r[i] <= {DATA_W{1'b0}};
        end else if (start_acc_s) begin
          for (int i = 0; i < r; i++) sk_r[i] <= {DATA_W{1'b0}};
        end else if (step_s) begin
          sk_r[0] <= a_src_s;
          for (int i = 1; i < r; i++) sk_r[i] <= sk_r[i-1];
        end
      end
      assign a_edge_s[r] = sk_r[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w_skew
    logic [DATA_W-1:0] w_src_s;
    assign w_src_s = (state_r == ST_FEED) ? bus.wgt_in[c*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    if (c == 0) begin : g_direct
      assign w_edge_s[c] = w_src_s;
    end else begin : g_delay
      logic [DATA_W-1:0] sk_r [c];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < c; i++) sk_r[i] <= {DATA_W{1'b0}};
        end else if (start_acc_s) begin
          for (int i = 0; i < c; i++) sk_r[i] <= {DATA_W{1'b0}};
        end else if (step_s) begin
          sk_r[0] <= w_src_s;
          for (int i = 1; i < c; i++) sk_r[i] <= sk_r[i-1];
        end
      end
      assign w_edge_s[c] = sk_r[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_W-1:0] a_in_s, w_in_s;
      if (c == 0) begin : g_a_edge
        assign a_in_s = a_edge_s[r];
      end else begin : g_a_chain
        assign a_in_s = a_pass_s[r][c-1];
      end
      if (r == 0) begin : g_w_edge
        assign w_in_s = w_edge_s[c];
      end else begin : g_w_chain
        assign w_in_s = w_pass_s[r-1][c];
      end
      sa_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc_s),
        .en    (step_s),
        .a_in  (a_in_s),
        .w_in  (w_in_s),
        .a_out (a_pass_s[r][c]),
        .w_out (w_pass_s[r][c]),
        .acc   (acc_s[r*COLS + c])
      );
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_row   = row_r;
  assign bus.res_col   = col_r;
  assign busy          = busy_r;
  assign done          = done_r;
endmodule
